// File: rtl/md_unit_pkg.sv
// Shared md_op encodings, decode record and helpers for the multiply/divide unit.
package md_unit_pkg;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MTHI  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MADD  = 4'd6;
  localparam logic [3:0] MD_MADDU = 4'd7;
  localparam logic [3:0] MD_MSUB  = 4'd8;
  localparam logic [3:0] MD_MSUBU = 4'd9;

  typedef enum logic {ST_IDLE, ST_RUN} md_state_e;

  typedef struct packed {
    logic valid;
    logic is_div;
    logic is_signed;
    logic is_acc;
    logic is_sub;
  } md_dec_t;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Only multi-cycle ops decode as valid; anything else on start is a no-op.
  function automatic md_dec_t md_decode(input logic [3:0] op, input logic madd_en);
    md_dec_t d;
    d = '0;
    case (op)
      MD_MULT:  begin d.valid = 1'b1; d.is_signed = 1'b1; end
      MD_MULTU: begin d.valid = 1'b1; end
      MD_DIV:   begin d.valid = 1'b1; d.is_div = 1'b1; d.is_signed = 1'b1; end
      MD_DIVU:  begin d.valid = 1'b1; d.is_div = 1'b1; end
      MD_MADD:  begin d.valid = madd_en; d.is_signed = 1'b1; d.is_acc = 1'b1; end
      MD_MADDU: begin d.valid = madd_en; d.is_acc = 1'b1; end
      MD_MSUB:  begin d.valid = madd_en; d.is_signed = 1'b1; d.is_acc = 1'b1; d.is_sub = 1'b1; end
      MD_MSUBU: begin d.valid = madd_en; d.is_acc = 1'b1; d.is_sub = 1'b1; end
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Loadable down-counter with IDLE/RUN state; busy spans exactly the loaded count.
module md_busy_ctr
  import md_unit_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          busy,
  output logic          last
);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_RUN;
          cnt_d   = load_val;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign last = busy & (cnt_q == CW'(1));

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu accumulating into {hi,lo}.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mt_we,
  output logic             busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

`ifdef MDU_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif
  localparam int CW = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
  localparam int W2 = 2 * WIDTH;

  md_dec_t          dec;
  logic             issue, mt_hi, mt_lo, last;
  logic [CW-1:0]    load_val;
  logic [W2-1:0]    hilo, a_ext, b_ext, prod, mul_res, div_res, shadow_d, shadow_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, divisor, q_mag, r_mag;

  assign dec      = md_decode(md_op, MADD_EN);
  assign issue    = start & ~busy & dec.valid;
  // start always wins over mt_we, even when start carries a no-op code.
  assign mt_hi    = mt_we & ~start & ~busy & (md_op == MD_MTHI);
  assign mt_lo    = mt_we & ~start & ~busy & (md_op == MD_MTLO);
  assign md_stall = start | busy;
  assign load_val = dec.is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
  assign hilo     = {hi_q, lo_q};

  always_comb begin
    a_ext   = dec.is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext   = dec.is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod    = a_ext * b_ext;
    mul_res = prod;
    if (dec.is_acc) mul_res = dec.is_sub ? (hilo - prod) : (hilo + prod);
  end

  // Divide on magnitudes so MIN_INT / -1 wraps to MIN_INT with a zero remainder.
  always_comb begin
    a_neg   = dec.is_signed & a[WIDTH-1];
    b_neg   = dec.is_signed & b[WIDTH-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    divisor = (b_mag == '0) ? WIDTH'(1) : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    div_res = (b == '0) ? hilo
                        : {(a_neg ? -r_mag : r_mag), ((a_neg ^ b_neg) ? -q_mag : q_mag)};
  end

  assign shadow_d = dec.is_div ? div_res : mul_res;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (issue) shadow_q <= shadow_d;
      if (last) begin
        hi_q <= shadow_q[W2-1:WIDTH];
        lo_q <= shadow_q[WIDTH-1:0];
      end else begin
        if (mt_hi) hi_q <= a;
        if (mt_lo) lo_q <= a;
      end
    end
  end

  md_busy_ctr #(
    .CW(CW)
  ) u_busy_ctr (
    .clk     (clk),
    .reset   (reset),
    .load    (issue),
    .load_val(load_val),
    .busy    (busy),
    .last    (last)
  );

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Randomized scoreboard bench for md_unit; expected HI/LO come from a 64-bit arithmetic model.
module tb_md_unit;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         mt_we = 1'b0;
  logic [3:0]   md_op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, md_stall;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
    .mt_we(mt_we), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    int          due;
    string       name;
  } exp_t;

  exp_t        lq[$];   // multi-cycle results, popped when busy falls
  exp_t        zq[$];   // zero-latency updates, popped on their due cycle
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares DUT state against queued expectations.
  initial begin : monitor
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run = 0;
      end else begin
        if (busy) begin
          run++;
        end else if (run > 0) begin
          if (lq.size() == 0) begin
            chk("unexpected_commit_len", 64'(run), 64'd0);
          end else begin
            e = lq.pop_front();
            chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
            chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
            chk({e.name, "_busy_len"}, 64'(run), 64'(e.len));
            $display("commit %s hi=%h lo=%h busy=%0d", e.name, hi, lo, run);
          end
          run = 0;
        end
        if (zq.size() > 0 && zq[0].due == cyc) begin
          e = zq.pop_front();
          chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
          chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
          $display("update %s hi=%h lo=%h", e.name, hi, lo);
        end
      end
    end
  end

  // Reference model: architectural effect of one issued op, in plain 64-bit arithmetic.
  function automatic int model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     acc, p, r;
    int              lat;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    acc = {m_hi, m_lo};
    r   = acc;
    lat = 0;
    case (op)
      4'd0: begin r = sx * sy; lat = MC; end
      4'd1: begin r = ux * uy; lat = MC; end
      4'd2: begin lat = DC; if (y != 0) r = {32'(sx % sy), 32'(sx / sy)}; end
      4'd3: begin lat = DC; if (y != 0) r = {32'(ux % uy), 32'(ux / uy)}; end
      4'd6, 4'd7, 4'd8, 4'd9: begin
        if (MADD) begin
          lat = MC;
          p = (op == 4'd6 || op == 4'd8) ? 64'(sx * sy) : 64'(ux * uy);
          r = (op < 4'd8) ? acc + p : acc - p;
        end
      end
      default: lat = 0;
    endcase
    {m_hi, m_lo} = r;
    return lat;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic with_mt, input string nm);
    exp_t e;
    wait_idle();
    md_op = op; a = x; b = y; start = 1'b1; mt_we = with_mt;
    e.len  = model(op, x, y);
    e.hi   = m_hi;
    e.lo   = m_lo;
    e.due  = cyc + 1;
    e.name = nm;
    if (e.len > 0) lq.push_back(e);
    else zq.push_back(e);
    @(negedge clk);
    chk({nm, "_start_busy"}, 64'(busy), 64'd0);
    chk({nm, "_start_stall"}, 64'(md_stall), 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0; mt_we = 1'b0;
  endtask

  task automatic mt(input logic hi_sel, input logic [31:0] x, input string nm);
    exp_t e;
    wait_idle();
    md_op = hi_sel ? 4'd4 : 4'd5; a = x; mt_we = 1'b1;
    if (hi_sel) m_hi = x;
    else m_lo = x;
    e.hi = m_hi; e.lo = m_lo; e.len = 0; e.due = cyc + 1; e.name = nm;
    zq.push_back(e);
    @(posedge clk);
    #1;
    mt_we = 1'b0;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0]  op;
    logic [31:0] x, y;
    #1 reset = 1'b0;
    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_stall", 64'(md_stall), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-divide must clear busy and HI/LO without a clock edge.
    mt(1'b1, 32'h55, "mthi_pre_reset");
    issue(4'd2, 32'd100, 32'd7, 1'b0, "div_abort");
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    lq.delete();
    zq.delete();
    m_hi = '0;
    m_lo = '0;
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    issue(4'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult_neg2x3");
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, "multu_neg2x3");
    issue(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7by2");
    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_by_m1");

    mt(1'b1, 32'h11, "mthi_11");
    mt(1'b0, 32'h22, "mtlo_22");
    issue(4'd3, 32'd1234, 32'd0, 1'b0, "divu_by0");

    mt(1'b1, 32'hDEAD, "mthi_dead");
    mt(1'b0, 32'hBEEF, "mtlo_beef");
    @(negedge clk);
    chk("mt_no_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // Protocol violations while busy are ignored.
    issue(4'd0, 32'd7, 32'd9, 1'b0, "mult_7x9_guarded");
    md_op = 4'd4; a = 32'hBAD0_BAD0; b = 32'd1; mt_we = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    md_op = 4'd2; start = 1'b1; mt_we = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    issue(4'd1, 32'd3, 32'd5, 1'b1, "multu_with_mt");

    mt(1'b1, 32'd0, "mthi_0");
    mt(1'b0, 32'd5, "mtlo_5");
    issue(4'd6, 32'd3, 32'd4, 1'b0, "madd_3x4");

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 9));
      x  = rnd_operand();
      y  = rnd_operand();
      if (op == 4'd4 || op == 4'd5) mt(op == 4'd4, x, $sformatf("rnd%0d_mt", i));
      else issue(op, x, y, 1'b0, $sformatf("rnd%0d_op%0d", i, op));
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("lq_drained", 64'(lq.size()), 64'd0);
    chk("zq_drained", 64'(zq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
